// File: rtl/ext_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ext_bus_pkg
// Purpose  : Shared types and default phase timing for the external bus
//            controller (state encoding, timing defaults, reload helper).
// Revision : 1.0 - initial release
// ============================================================================
package ext_bus_pkg;

  // Default phase lengths in clock cycles (each legal range is 1..15)
  localparam int unsigned TURN_CYC_DEF   = 1;
  localparam int unsigned STROBE_CYC_DEF = 2;
  localparam int unsigned HOLD_CYC_DEF   = 1;

  // Explicit 3-bit encoding so the state register width is fixed
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4,
    ST_TURN   = 3'd5,
    ST_RESP   = 3'd6
  } state_e;

  // A phase of N cycles loads N-1; the phase ends on the cycle the timer reads zero
  function automatic logic [3:0] phase_reload(input int unsigned cycles);
    logic [3:0] r;
    r = 4'(cycles - 1);
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ext_bus_if.sv
`default_nettype none
// ============================================================================
// Module   : ext_bus_if
// Purpose  : Core request/response handshake plus transceiver and device bus
//            signals of the external bus controller, bundled as one interface.
// Revision : 1.0 - initial release
// ============================================================================
interface ext_bus_if;

  // Core request channel
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;

  // Core response channel
  logic       resp_valid;
  logic       resp_ready;
  logic [7:0] resp_rdata;

  // Transceiver and device side
  logic       xcvr_dir;
  logic       xcvr_oe_n;
  logic [3:0] bus_addr;
  logic [7:0] bus_dout;
  logic       bus_doe;
  logic [7:0] bus_din;
  logic       bus_wr_n;
  logic       bus_rd_n;

  // Controller view
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready, bus_din,
    output req_ready, resp_valid, resp_rdata,
    output xcvr_dir, xcvr_oe_n, bus_addr, bus_dout, bus_doe, bus_wr_n, bus_rd_n
  );

  // Core plus device-model view
  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready, bus_din,
    input  req_ready, resp_valid, resp_rdata,
    input  xcvr_dir, xcvr_oe_n, bus_addr, bus_dout, bus_doe, bus_wr_n, bus_rd_n
  );

endinterface
`default_nettype wire

// File: rtl/ext_bus_timer.sv
`default_nettype none
// ============================================================================
// Module   : ext_bus_timer
// Purpose  : Loadable 4-bit down-counter with zero flag used to time every
//            bus phase. It counts down to zero and then holds there.
// Revision : 1.0 - initial release
// ============================================================================
module ext_bus_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic       zero_o
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  // Reload on request, otherwise count down and saturate at zero
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != 4'd0) begin
      count_d = count_q - 4'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == 4'd0);

endmodule
`default_nettype wire

// File: rtl/ext_bus_ctl.sv
`default_nettype none
// ============================================================================
// Module   : ext_bus_ctl
// Purpose  : Sequences one 8-bit device access per request over an external
//            transceiver: address, transceiver turn-on, strobe, hold and
//            turn-off, then returns a response to the core.
// Revision : 1.0 - initial release
// ============================================================================
module ext_bus_ctl
  import ext_bus_pkg::*;
#(
  parameter int unsigned TURN_CYC   = TURN_CYC_DEF,
  parameter int unsigned STROBE_CYC = STROBE_CYC_DEF,
  parameter int unsigned HOLD_CYC   = HOLD_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  ext_bus_if.slave ctl
);

  localparam logic [3:0] C_TURN_RELOAD   = phase_reload(TURN_CYC);
  localparam logic [3:0] C_STROBE_RELOAD = phase_reload(STROBE_CYC);
  localparam logic [3:0] C_HOLD_RELOAD   = phase_reload(HOLD_CYC);

  state_e     state_q;
  state_e     state_d;

  // Transaction context captured at acceptance; dir_q doubles as the write flag
  logic       dir_q;
  logic [3:0] addr_q;
  logic [7:0] wdata_q;
  logic [7:0] rdata_q;

  logic       tmr_load;
  logic [3:0] tmr_load_val;
  logic       tmr_zero;

  logic       accept;
  logic       rd_capture;
  logic       xcvr_on;

  assign accept     = (state_q == ST_IDLE) && ctl.req_valid;
  assign rd_capture = (state_q == ST_STROBE) && tmr_zero && !dir_q;

  ext_bus_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .zero_o     (tmr_zero)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: each timed phase advances when the timer reaches zero
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (ctl.req_valid)  state_d = ST_ADDR;
      ST_ADDR:   if (tmr_zero)       state_d = ST_SETUP;
      ST_SETUP:  if (tmr_zero)       state_d = ST_STROBE;
      ST_STROBE: if (tmr_zero)       state_d = ST_HOLD;
      ST_HOLD:   if (tmr_zero)       state_d = ST_TURN;
      ST_TURN:   if (tmr_zero)       state_d = ST_RESP;
      ST_RESP:   if (ctl.resp_ready) state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  // Timer reload on every state entry with the length of the phase being entered
  always_comb begin
    tmr_load     = (state_d != state_q);
    tmr_load_val = 4'd0;
    unique case (state_d)
      ST_SETUP:  tmr_load_val = C_TURN_RELOAD;
      ST_STROBE: tmr_load_val = C_STROBE_RELOAD;
      ST_HOLD:   tmr_load_val = C_HOLD_RELOAD;
      ST_TURN:   tmr_load_val = C_TURN_RELOAD;
      default:   tmr_load_val = 4'd0;
    endcase
  end

  // Transaction context: request fields at acceptance, read data at the end of the strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q   <= 1'b0;
      addr_q  <= 4'd0;
      wdata_q <= 8'd0;
      rdata_q <= 8'd0;
    end else begin
      if (accept) begin
        dir_q   <= ctl.req_we;
        addr_q  <= ctl.req_addr;
        wdata_q <= ctl.req_wdata;
      end
      if (rd_capture) begin
        rdata_q <= ctl.bus_din;
      end
    end
  end

  // Output decode: transceiver is enabled only from SETUP through HOLD
  always_comb begin
    xcvr_on        = (state_q == ST_SETUP) || (state_q == ST_STROBE) || (state_q == ST_HOLD);
    ctl.req_ready  = (state_q == ST_IDLE);
    ctl.resp_valid = (state_q == ST_RESP);
    ctl.resp_rdata = rdata_q;
    ctl.xcvr_dir   = dir_q;
    ctl.xcvr_oe_n  = !xcvr_on;
    ctl.bus_addr   = addr_q;
    ctl.bus_dout   = wdata_q;
    // Gating with dir_q keeps the A-side driver off whenever the transceiver points B->A
    ctl.bus_doe    = xcvr_on && dir_q;
    ctl.bus_wr_n   = !((state_q == ST_STROBE) && dir_q);
    ctl.bus_rd_n   = !((state_q == ST_STROBE) && !dir_q);
  end

endmodule
`default_nettype wire

// File: tb/tb_ext_bus_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ext_bus_ctl
// Purpose  : Self-checking bench for ext_bus_ctl: vector table of accesses,
//            read-data scoreboard, per-cycle bus invariants, reset abort,
//            non-default timing instance and random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ext_bus_ctl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  ext_bus_if bif_a ();
  ext_bus_if bif_b ();

  ext_bus_ctl u_dut_a (
    .clk   (clk),
    .reset (reset),
    .ctl   (bif_a)
  );

  ext_bus_ctl #(
    .TURN_CYC   (3),
    .STROBE_CYC (1),
    .HOLD_CYC   (2)
  ) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .ctl   (bif_b)
  );

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] sbq[$];
  logic [7:0] model_rdata;

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] din;
    int         resp_wait;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle bus invariants on instance A
  logic       mon_en    = 1'b0;
  logic       edge_acc  = 1'b0;
  logic       edge_rst  = 1'b0;
  logic       prev_dir  = 1'b0;
  logic       prev_oe_n = 1'b1;
  logic [3:0] prev_addr = 4'd0;

  always @(posedge clk) begin
    edge_acc = bif_a.req_valid && bif_a.req_ready;
    edge_rst = reset;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("inv_doe_while_dir_read", {31'd0, bif_a.bus_doe & ~bif_a.xcvr_dir}, 0);
      check("inv_rd_wr_both_low", {31'd0, ~bif_a.bus_rd_n & ~bif_a.bus_wr_n}, 0);
      if (bif_a.xcvr_dir !== prev_dir) begin
        check("dir_change_only_on_accept", {31'd0, edge_acc | edge_rst}, 1);
        if (!edge_rst) check("dir_change_only_oe_off", {31'd0, bif_a.xcvr_oe_n & prev_oe_n}, 1);
      end
      if (bif_a.bus_addr !== prev_addr)
        check("addr_change_only_on_accept", {31'd0, edge_acc | edge_rst}, 1);
      prev_dir  = bif_a.xcvr_dir;
      prev_oe_n = bif_a.xcvr_oe_n;
      prev_addr = bif_a.bus_addr;
    end
  end

  // One access on instance A (defaults: TURN 1, STROBE 2, HOLD 1)
  task automatic run_a(input logic we, input logic [3:0] addr, input logic [7:0] wdata,
                       input logic [7:0] din, input int resp_wait, input logic [7:0] exp_rdata);
    int n, lat, oe_lo, wr_lo, rd_lo, doe_hi;
    logic [7:0] held;
    n = 0;
    while (bif_a.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("a_req_ready_idle", {31'd0, bif_a.req_ready}, 1);
    bif_a.req_valid = 1'b1;
    bif_a.req_we    = we;
    bif_a.req_addr  = addr;
    bif_a.req_wdata = wdata;
    bif_a.bus_din   = ~din;
    sbq.push_back(exp_rdata);
    @(negedge clk);
    // Scramble request fields after acceptance; the DUT must use its captured copy
    bif_a.req_valid = 1'b0;
    bif_a.req_we    = ~we;
    bif_a.req_addr  = ~addr;
    bif_a.req_wdata = ~wdata;
    check("a_addr_phase_dir", {31'd0, bif_a.xcvr_dir}, {31'd0, we});
    check("a_addr_phase_addr", {28'd0, bif_a.bus_addr}, {28'd0, addr});
    check("a_addr_phase_oe_n", {31'd0, bif_a.xcvr_oe_n}, 1);
    lat = 0; oe_lo = 0; wr_lo = 0; rd_lo = 0; doe_hi = 0;
    while (bif_a.resp_valid !== 1'b1 && lat < 40) begin
      check("a_busy_req_ready", {31'd0, bif_a.req_ready}, 0);
      if (bif_a.xcvr_oe_n === 1'b0) oe_lo++;
      if (bif_a.bus_wr_n === 1'b0) wr_lo++;
      if (bif_a.bus_rd_n === 1'b0) rd_lo++;
      if (bif_a.bus_doe === 1'b1) begin
        doe_hi++;
        check("a_bus_dout", {24'd0, bif_a.bus_dout}, {24'd0, wdata});
      end
      check("a_addr_stable", {28'd0, bif_a.bus_addr}, {28'd0, addr});
      // Valid data only in the last strobe cycle, so capture timing is exact
      bif_a.bus_din = (bif_a.bus_rd_n === 1'b0 && rd_lo == 2) ? din : ~din;
      @(negedge clk);
      lat++;
    end
    check("a_latency", lat, 6);
    check("a_oe_low_cycles", oe_lo, 4);
    check("a_wr_low_cycles", wr_lo, we ? 2 : 0);
    check("a_rd_low_cycles", rd_lo, we ? 0 : 2);
    check("a_doe_high_cycles", doe_hi, we ? 4 : 0);
    held = bif_a.resp_rdata;
    repeat (resp_wait) begin
      check("a_resp_valid_held", {31'd0, bif_a.resp_valid}, 1);
      check("a_resp_rdata_stable", {24'd0, bif_a.resp_rdata}, {24'd0, held});
      check("a_resp_req_ready", {31'd0, bif_a.req_ready}, 0);
      @(negedge clk);
    end
    bif_a.resp_ready = 1'b1;
    check("a_resp_valid", {31'd0, bif_a.resp_valid}, 1);
    if (sbq.size() == 0) check("a_scoreboard_empty", 0, 1);
    else check("a_resp_rdata", {24'd0, bif_a.resp_rdata}, {24'd0, sbq.pop_front()});
    @(negedge clk);
    bif_a.resp_ready = 1'b0;
    check("a_resp_valid_drop", {31'd0, bif_a.resp_valid}, 0);
    check("a_back_to_idle", {31'd0, bif_a.req_ready}, 1);
  endtask

  // One access on instance B (TURN 3, STROBE 1, HOLD 2)
  task automatic run_b(input logic we, input logic [3:0] addr, input logic [7:0] wdata,
                       input logic [7:0] din, input logic [7:0] exp_rdata);
    int n, lat, oe_lo, st_lo;
    n = 0;
    while (bif_b.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("b_req_ready_idle", {31'd0, bif_b.req_ready}, 1);
    bif_b.req_valid = 1'b1;
    bif_b.req_we    = we;
    bif_b.req_addr  = addr;
    bif_b.req_wdata = wdata;
    bif_b.bus_din   = ~din;
    sbq.push_back(exp_rdata);
    @(negedge clk);
    bif_b.req_valid = 1'b0;
    lat = 0; oe_lo = 0; st_lo = 0;
    while (bif_b.resp_valid !== 1'b1 && lat < 40) begin
      if (bif_b.xcvr_oe_n === 1'b0) oe_lo++;
      if (bif_b.bus_wr_n === 1'b0 || bif_b.bus_rd_n === 1'b0) st_lo++;
      bif_b.bus_din = (bif_b.bus_rd_n === 1'b0) ? din : ~din;
      @(negedge clk);
      lat++;
    end
    check("b_latency", lat, 10);
    check("b_oe_low_cycles", oe_lo, 6);
    check("b_strobe_low_cycles", st_lo, 1);
    bif_b.resp_ready = 1'b1;
    if (sbq.size() == 0) check("b_scoreboard_empty", 0, 1);
    else check("b_resp_rdata", {24'd0, bif_b.resp_rdata}, {24'd0, sbq.pop_front()});
    @(negedge clk);
    bif_b.resp_ready = 1'b0;
    check("b_back_to_idle", {31'd0, bif_b.req_ready}, 1);
  endtask

  initial begin
    int n;
    logic we;
    logic [7:0] din, exp;

    vecs[0] = '{1'b1, 4'h3, 8'hA5, 8'h00, 0, 8'h00};
    vecs[1] = '{1'b0, 4'h7, 8'h00, 8'h5A, 0, 8'h5A};
    vecs[2] = '{1'b0, 4'h2, 8'h11, 8'h3C, 3, 8'h3C};
    vecs[3] = '{1'b1, 4'h9, 8'h81, 8'hEE, 3, 8'h3C};
    vecs[4] = '{1'b0, 4'hF, 8'h00, 8'hFF, 1, 8'hFF};
    vecs[5] = '{1'b1, 4'h0, 8'h00, 8'h12, 0, 8'hFF};
    vecs[6] = '{1'b0, 4'h0, 8'hFF, 8'h00, 2, 8'h00};

    reset = 1'b1;
    bif_a.req_valid = 1'b0; bif_a.req_we = 1'b0; bif_a.req_addr = 4'd0;
    bif_a.req_wdata = 8'd0; bif_a.resp_ready = 1'b0; bif_a.bus_din = 8'd0;
    bif_b.req_valid = 1'b0; bif_b.req_we = 1'b0; bif_b.req_addr = 4'd0;
    bif_b.req_wdata = 8'd0; bif_b.resp_ready = 1'b0; bif_b.bus_din = 8'd0;
    repeat (3) @(negedge clk);

    check("rst_xcvr_oe_n", {31'd0, bif_a.xcvr_oe_n}, 1);
    check("rst_xcvr_dir", {31'd0, bif_a.xcvr_dir}, 0);
    check("rst_bus_doe", {31'd0, bif_a.bus_doe}, 0);
    check("rst_bus_rd_n", {31'd0, bif_a.bus_rd_n}, 1);
    check("rst_bus_wr_n", {31'd0, bif_a.bus_wr_n}, 1);
    check("rst_resp_valid", {31'd0, bif_a.resp_valid}, 0);
    check("rst_resp_rdata", {24'd0, bif_a.resp_rdata}, 0);
    check("rst_bus_addr", {28'd0, bif_a.bus_addr}, 0);
    check("rst_bus_dout", {24'd0, bif_a.bus_dout}, 0);
    check("rst_req_ready", {31'd0, bif_a.req_ready}, 1);
    reset = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 7; i++)
      run_a(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].din, vecs[i].resp_wait, vecs[i].exp_rdata);
    model_rdata = vecs[6].exp_rdata;

    // Reset while a write is strobing: transaction is dropped with no response
    bif_a.req_valid = 1'b1; bif_a.req_we = 1'b1; bif_a.req_addr = 4'h5; bif_a.req_wdata = 8'h3C;
    @(negedge clk);
    bif_a.req_valid = 1'b0;
    n = 0;
    while (bif_a.bus_wr_n !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    check("abort_reached_strobe", {31'd0, bif_a.bus_wr_n}, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_oe_n", {31'd0, bif_a.xcvr_oe_n}, 1);
    check("abort_wr_n", {31'd0, bif_a.bus_wr_n}, 1);
    check("abort_doe", {31'd0, bif_a.bus_doe}, 0);
    check("abort_dir", {31'd0, bif_a.xcvr_dir}, 0);
    check("abort_rdata", {24'd0, bif_a.resp_rdata}, 0);
    check("abort_req_ready", {31'd0, bif_a.req_ready}, 1);
    model_rdata = 8'd0;
    bif_a.resp_ready = 1'b1;
    repeat (8) begin
      check("abort_no_resp", {31'd0, bif_a.resp_valid}, 0);
      @(negedge clk);
    end
    bif_a.resp_ready = 1'b0;

    // Non-default timing instance
    run_b(1'b1, 4'h1, 8'hC3, 8'h00, 8'h00);
    run_b(1'b0, 4'h2, 8'h00, 8'h96, 8'h96);

    // Random traffic with the invariant monitor running
    for (int i = 0; i < 1000; i++) begin
      we  = 1'($urandom_range(0, 1));
      din = 8'($urandom);
      exp = we ? model_rdata : din;
      model_rdata = exp;
      run_a(we, 4'($urandom), 8'($urandom), din, int'($urandom_range(0, 2)), exp);
    end

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
